// File: rtl/led_dimmer_pkg.sv
// Shared constants, types and duty lookup for the LED PWM dimmer.
// Defining LED_DIMMER_OFF_LEVEL_EN adds a fifth brightness level that holds every LED off.
package led_dimmer_pkg;

`ifdef LED_DIMMER_OFF_LEVEL_EN
    localparam int LEVELS = 5;
`else
    localparam int LEVELS = 4;
`endif

    typedef logic [2:0] level_t;

    typedef enum logic {
        DB_IDLE,
        DB_COUNT
    } db_state_t;

    // Power of two whose fractional results (negative exponent) are clamped up to 1.
    function automatic int unsigned pow2_clamped(input int exponent);
        int unsigned result;
        if (exponent < 0)
            result = 1;
        else
            result = 32'd1 << exponent;
        return result;
    endfunction

    // Level 4 only exists with the off-level build; it falls into the zero-duty default.
    function automatic int unsigned duty(input level_t level, input int pwm_bits);
        int unsigned result;
        case (level)
            3'd0:    result = pow2_clamped(pwm_bits);
            3'd1:    result = pow2_clamped(pwm_bits - 1);
            3'd2:    result = pow2_clamped(pwm_bits - 3);
            3'd3:    result = pow2_clamped(pwm_bits - 5);
            default: result = 0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a counting debounce FSM for the brightness button.
module debounce_filter
    import led_dimmer_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Raw,
    output logic o_Clean
);

    localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync_1;
    logic             sync_2;
    logic             clean;
    logic             next_clean;
    db_state_t        state;
    db_state_t        next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            state  <= DB_IDLE;
            count  <= '0;
            clean  <= 1'b0;
        end else begin
            sync_1 <= i_Raw;
            sync_2 <= sync_1;
            state  <= next_state;
            count  <= next_count;
            clean  <= next_clean;
        end
    end

    // Any return to the accepted value before the limit throws away the progress so far.
    always_comb begin
        next_state = state;
        next_count = count;
        next_clean = clean;
        case (state)
            DB_IDLE: begin
                next_count = '0;
                if (sync_2 != clean)
                    next_state = DB_COUNT;
            end
            DB_COUNT: begin
                if (sync_2 == clean) begin
                    next_state = DB_IDLE;
                    next_count = '0;
                end else if (count == LAST_COUNT) begin
                    next_clean = sync_2;
                    next_state = DB_IDLE;
                    next_count = '0;
                end else begin
                    next_count = count + CNT_W'(1);
                end
            end
        endcase
    end

    assign o_Clean = clean;

endmodule

// File: rtl/led_pwm_dimmer.sv
// Gates four blink waveforms with a shared PWM whose duty is stepped by a debounced button.
// Build option: LED_DIMMER_OFF_LEVEL_EN (via led_dimmer_pkg) adds an all-off level.
module led_pwm_dimmer
    import led_dimmer_pkg::*;
#(
    parameter int PWM_BITS       = 8,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [3:0] i_LED,
    input  logic       i_Switch,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [2:0] o_Level
);

    localparam int                  DUTY_W     = PWM_BITS + 1;
    localparam level_t              LAST_LEVEL = level_t'(LEVELS - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
    localparam logic [DUTY_W-1:0]   RESET_DUTY = DUTY_W'(duty(level_t'(0), PWM_BITS));

    logic                clean;
    logic                clean_prev;
    logic                press;
    logic                wrap;
    logic                pwm_on;
    level_t              level;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DUTY_W-1:0]   active_duty;
    logic [3:0]          led;

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Raw   (i_Switch),
        .o_Clean (clean)
    );

    assign press  = clean & ~clean_prev;
    assign wrap   = (pwm_cnt == CNT_MAX);
    assign pwm_on = ({1'b0, pwm_cnt} < active_duty);

    // Duty is only reloaded at the period boundary, so a press never produces a runt pulse.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            clean_prev  <= 1'b0;
            level       <= '0;
            pwm_cnt     <= '0;
            active_duty <= RESET_DUTY;
            led         <= '0;
        end else begin
            clean_prev <= clean;
            if (press)
                level <= (level == LAST_LEVEL) ? '0 : level + 3'd1;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (wrap)
                active_duty <= DUTY_W'(duty(level, PWM_BITS));
            led <= i_LED & {4{pwm_on}};
        end
    end

    assign o_LED_1 = led[0];
    assign o_LED_2 = led[1];
    assign o_LED_3 = led[2];
    assign o_LED_4 = led[3];
    assign o_Level = level;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Directed bench for led_pwm_dimmer with PWM_BITS=4 and DEBOUNCE_LIMIT=4.
`timescale 1ns/1ps
module tb_led_pwm_dimmer;

    localparam int PWM_BITS       = 4;
    localparam int DEBOUNCE_LIMIT = 4;
    localparam int PERIOD         = 16;

`ifdef LED_DIMMER_OFF_LEVEL_EN
    localparam int N_STEPS = 4;
    int step_level [N_STEPS] = '{2, 3, 4, 0};
    int step_duty  [N_STEPS] = '{2, 1, 0, 16};
`else
    localparam int N_STEPS = 3;
    int step_level [N_STEPS] = '{2, 3, 0};
    int step_duty  [N_STEPS] = '{2, 1, 16};
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] led_in;
    logic       sw;
    logic       led_1;
    logic       led_2;
    logic       led_3;
    logic       led_4;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    always #5 clk = ~clk;

    led_pwm_dimmer #(
        .PWM_BITS       (PWM_BITS),
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) dut (
        .i_Clk    (clk),
        .i_Rst_L  (rst_n),
        .i_LED    (led_in),
        .i_Switch (sw),
        .o_LED_1  (led_1),
        .o_LED_2  (led_2),
        .o_LED_3  (led_3),
        .o_LED_4  (led_4),
        .o_Level  (level)
    );

    // Independent count of clock edges since reset release; the PWM phase is derived from it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            edges <= 0;
        else
            edges <= edges + 1;
    end

    function automatic logic [3:0] leds();
        return {led_4, led_3, led_2, led_1};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++)
            @(negedge clk);
    endtask

    task automatic press_button();
        sw = 1'b1;
        tick(12);
        sw = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        led_in = 4'b1111;
        sw     = 1'b0;
        tick(3);
        checks++;
        if (leds() !== 4'b0000 || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: leds=%b level=%0d, expected leds=0000 level=0", leds(), level);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++;
            if (leds() !== 4'b1111) begin
                errors++;
                $display("[TB] FAIL full_duty cycle %0d: leds=%b, expected 1111", i, leds());
            end
        end
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL level_after_reset: level=%0d, expected 0", level);
        end
    endtask

    task automatic test_led_pattern();
        led_in = 4'b0101;
        tick(1);
        checks++;
        if (leds() !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL pattern_0101: leds=%b, expected 0101", leds());
        end
        led_in = 4'b0100;
        #1;
        checks++;
        if (leds() !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL pattern_latency: leds=%b, expected 0101 before the clock", leds());
        end
        tick(1);
        checks++;
        if (leds() !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL pattern_follow: leds=%b, expected 0100", leds());
        end
        led_in = 4'b1111;
        tick(1);
    endtask

    task automatic test_clean_press();
        int         cnt_seen;
        logic [3:0] expected;
        sw = 1'b1;
        tick(5);
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL press_too_early: level=%0d, expected 0", level);
        end
        tick(5);
        sw = 1'b0;
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL press_level1: level=%0d, expected 1", level);
        end
        tick(10 + 2 * PERIOD);
        for (int i = 0; i < PERIOD; i++) begin
            tick(1);
            cnt_seen = (edges - 1) % PERIOD;
            expected = (cnt_seen < 8) ? led_in : 4'b0000;
            checks++;
            if (leds() !== expected) begin
                errors++;
                $display("[TB] FAIL duty_level1 cnt=%0d: leds=%b, expected %b", cnt_seen, leds(), expected);
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0);
            tick(2);
        end
        sw = 1'b0;
        tick(15);
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL bounce_rejected: level=%0d, expected 1", level);
        end
    endtask

    task automatic test_level_cycle();
        int         cnt_seen;
        logic [3:0] expected;
        for (int s = 0; s < N_STEPS; s++) begin
            press_button();
            checks++;
            if (level !== 3'(step_level[s])) begin
                errors++;
                $display("[TB] FAIL level_step %0d: level=%0d, expected %0d", s, level, step_level[s]);
            end
            tick(2 * PERIOD);
            for (int i = 0; i < PERIOD; i++) begin
                tick(1);
                cnt_seen = (edges - 1) % PERIOD;
                expected = (cnt_seen < step_duty[s]) ? led_in : 4'b0000;
                checks++;
                if (leds() !== expected) begin
                    errors++;
                    $display("[TB] FAIL duty_level%0d cnt=%0d: leds=%b, expected %b",
                             step_level[s], cnt_seen, leds(), expected);
                end
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        press_button();
        press_button();
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("[TB] FAIL setup_level2: level=%0d, expected 2", level);
        end
        sw = 1'b1;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (leds() !== 4'b0000 || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: leds=%b level=%0d, expected leds=0000 level=0", leds(), level);
        end
        sw = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (leds() !== 4'b1111 || level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL after_reset: leds=%b level=%0d, expected leds=1111 level=0", leds(), level);
        end
        tick(12);
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL no_stray_press: level=%0d, expected 0", level);
        end
    endtask

    initial begin
        test_reset();
        test_led_pattern();
        test_clean_press();
        test_bounce();
        test_level_cycle();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
